// File: rtl/fixed_point_square_pkg.sv
// Shared fixed-point format helpers for the square-root / square pair:
// FSM state encoding and derived datapath widths.
package fixed_point_square_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } fps_state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ACC_W = 2 * DEF_WIDTH + 1;
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH) + 1;

  // One guard bit above 2*WIDTH so root^2 + rem can never wrap.
  function automatic int acc_width(input int width);
    return 2 * width + 1;
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/fixed_point_square_if.sv
// Start/busy/valid handshake and operand/result bus of the fixed-point squarer.
interface fixed_point_square_if #(
  parameter int WIDTH = 16
) ();

  logic             i_start;
  logic [WIDTH-1:0] i_root;
  logic [WIDTH-1:0] i_rem;
  logic             o_busy;
  logic             o_valid;
  logic [WIDTH-1:0] o_rad;
  logic             o_exact;
  logic             o_ovf;

  modport master (
    output i_start, i_root, i_rem,
    input  o_busy, o_valid, o_rad, o_exact, o_ovf
  );

  modport slave (
    input  i_start, i_root, i_rem,
    output o_busy, o_valid, o_rad, o_exact, o_ovf
  );

endinterface

// File: rtl/fixed_point_square.sv
// Sequential shift-add squarer: o_rad = (root*root + rem) >> FRACT_BITS,
// one multiplier bit per clock, fixed latency of WIDTH+1 edges after start.
module fixed_point_square
  import fixed_point_square_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FRACT_BITS = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  fixed_point_square_if.slave   sq
);

  localparam int ACC_W = acc_width(WIDTH);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [ACC_W-1:0] FRAC_MASK = (ACC_W'(1) << FRACT_BITS) - ACC_W'(1);

  fps_state_e         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               valid_q, valid_d;
  logic [WIDTH-1:0]   rad_q, rad_d;
  logic               exact_q, exact_d;
  logic               ovf_q, ovf_d;
  logic               ovf_w;

  // Anything at or above bit FRACT_BITS+WIDTH cannot be represented in o_rad.
  assign ovf_w = |(acc_q >> (FRACT_BITS + WIDTH));

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    valid_d  = valid_q;
    rad_d    = rad_q;
    exact_d  = exact_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (sq.i_start) begin
          acc_d    = {{(ACC_W-WIDTH){1'b0}}, sq.i_rem};
          mcand_d  = {{WIDTH{1'b0}}, sq.i_root};
          mplier_d = sq.i_root;
          count_d  = '0;
          valid_d  = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (mplier_q[0]) begin
          acc_d = acc_q + {1'b0, mcand_q};
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CNT_W'(1);
        // No early-out: always WIDTH adds so latency is operand-independent.
        if (count_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FINAL;
        end
      end
      ST_FINAL: begin
        rad_d   = ovf_w ? '1 : acc_q[FRACT_BITS +: WIDTH];
        ovf_d   = ovf_w;
        exact_d = ((acc_q & FRAC_MASK) == '0);
        valid_d = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      rad_q    <= '0;
      exact_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      rad_q    <= rad_d;
      exact_q  <= exact_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sq.o_busy  = (state_q == ST_RUN) || (state_q == ST_FINAL);
  assign sq.o_valid = valid_q;
  assign sq.o_rad   = rad_q;
  assign sq.o_exact = exact_q;
  assign sq.o_ovf   = ovf_q;

endmodule
